// File: rtl/game_pkg.sv
// Shared encodings for the game-flow controller: one-hot states, match results
// and a saturating score increment.
package game_pkg;

   localparam logic [5:0] ST_START = 6'b000001;
   localparam logic [5:0] ST_PLAY  = 6'b000010;
   localparam logic [5:0] ST_END   = 6'b000100;
   localparam logic [5:0] ST_READY = 6'b001000;
   localparam logic [5:0] ST_RWIN  = 6'b010000;
   localparam logic [5:0] ST_RLOSE = 6'b100000;

   localparam logic [1:0] RES_NONE = 2'b00;
   localparam logic [1:0] RES_WIN  = 2'b01;
   localparam logic [1:0] RES_LOSE = 2'b10;
   localparam logic [1:0] RES_DRAW = 2'b11;

   typedef enum logic [5:0] {
      S_START = ST_START,
      S_PLAY  = ST_PLAY,
      S_END   = ST_END,
      S_READY = ST_READY,
      S_RWIN  = ST_RWIN,
      S_RLOSE = ST_RLOSE
   } game_state_t;

   function automatic logic [3:0] sat_inc(input logic [3:0] value);
      return (value == 4'hF) ? value : value + 4'd1;
   endfunction

endpackage

// File: rtl/game_state_ctrl_edge_sync_pulse.sv
// Rising-edge pulse generator with an optional 2-FF synchronizer in front.
// SYNC_EN=0 registers the input once before edge detection.
module edge_sync_pulse #(
   parameter bit SYNC_EN = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic pulse
);

   logic level_q;
   logic prev_q;

   generate
      if (SYNC_EN) begin : g_sync
         logic meta_q;
         // NOTE: sequential state uses non-blocking assignments so the two
         // flops shift as a chain rather than collapsing into one.
         always_ff @(posedge clk) begin
            if (rst) begin
               meta_q  <= 1'b0;
               level_q <= 1'b0;
            end else begin
               meta_q  <= din;
               level_q <= meta_q;
            end
         end
      end else begin : g_nosync
         always_ff @(posedge clk) begin
            if (rst) level_q <= 1'b0;
            else     level_q <= din;
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) prev_q <= 1'b0;
      else     prev_q <= level_q;
   end

   assign pulse = level_q & ~prev_q;

endmodule

// File: rtl/game_state_ctrl.sv
// Game-flow controller: START -> READY -> PLAY -> RWIN/RLOSE -> ... -> END,
// timed in vsync frames. Define GAME_TIMEOUT_EN to end PLAY as a draw after
// TIMEOUT_FRAMES frames without a round result.
module game_state_ctrl
   import game_pkg::*;
#(
   parameter int WIN_ROUNDS     = 3,
   parameter int READY_FRAMES   = 120,
   parameter int ROUND_FRAMES   = 60,
   parameter int END_FRAMES     = 300,
   parameter int TIMEOUT_FRAMES = 3600
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       vsync,
   input  logic       btn_start,
   input  logic       round_win,
   input  logic       round_lose,
   output logic [5:0] state_bin,
   output logic [1:0] resoult,
   output logic [3:0] score_win,
   output logic [3:0] score_lose
);

`ifdef GAME_TIMEOUT_EN
   localparam bit TIMEOUT_EN = 1'b1;
`else
   localparam bit TIMEOUT_EN = 1'b0;
`endif

   localparam logic [15:0] READY_LAST   = 16'(READY_FRAMES - 1);
   localparam logic [15:0] ROUND_LAST   = 16'(ROUND_FRAMES - 1);
   localparam logic [15:0] END_SAT      = 16'(END_FRAMES);
   localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_FRAMES - 1);
   localparam logic [3:0]  WIN_TARGET   = 4'(WIN_ROUNDS);

   logic        frame_tick;
   logic        start_pulse;

   game_state_t state_q, state_next;
   logic [1:0]  res_q, res_next;
   logic [3:0]  win_q, win_next;
   logic [3:0]  lose_q, lose_next;
   logic [15:0] frame_cnt, cnt_next;

   edge_sync_pulse #(.SYNC_EN(1'b1)) u_start_sync (
      .clk   (clk),
      .rst   (rst),
      .din   (btn_start),
      .pulse (start_pulse)
   );

   edge_sync_pulse #(.SYNC_EN(1'b0)) u_vsync_edge (
      .clk   (clk),
      .rst   (rst),
      .din   (vsync),
      .pulse (frame_tick)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_START;
         res_q     <= RES_NONE;
         win_q     <= 4'd0;
         lose_q    <= 4'd0;
         frame_cnt <= 16'd0;
      end else begin
         state_q   <= state_next;
         res_q     <= res_next;
         win_q     <= win_next;
         lose_q    <= lose_next;
         frame_cnt <= cnt_next;
      end
   end

   // NOTE: every output of this block is given a hold value first so that no
   // path through the case leaves one unassigned and infers a latch.
   always_comb begin
      state_next = state_q;
      res_next   = res_q;
      win_next   = win_q;
      lose_next  = lose_q;
      cnt_next   = frame_cnt;

      case (state_q)
         S_START: begin
            if (start_pulse) begin
               state_next = S_READY;
               win_next   = 4'd0;
               lose_next  = 4'd0;
               cnt_next   = 16'd0;
            end
         end

         S_READY: begin
            if (frame_tick) begin
               if (frame_cnt == READY_LAST) begin
                  state_next = S_PLAY;
                  cnt_next   = 16'd0;
               end else begin
                  cnt_next = frame_cnt + 16'd1;
               end
            end
         end

         S_PLAY: begin
            // A lost round outranks a simultaneous win; any round result
            // outranks the timeout.
            if (round_lose) begin
               state_next = S_RLOSE;
               lose_next  = sat_inc(lose_q);
               cnt_next   = 16'd0;
            end else if (round_win) begin
               state_next = S_RWIN;
               win_next   = sat_inc(win_q);
               cnt_next   = 16'd0;
            end else if (TIMEOUT_EN && frame_tick) begin
               if (frame_cnt == TIMEOUT_LAST) begin
                  state_next = S_END;
                  res_next   = RES_DRAW;
                  cnt_next   = 16'd0;
               end else begin
                  cnt_next = frame_cnt + 16'd1;
               end
            end
         end

         S_RWIN, S_RLOSE: begin
            if (frame_tick) begin
               if (frame_cnt == ROUND_LAST) begin
                  cnt_next = 16'd0;
                  if (win_q == WIN_TARGET) begin
                     state_next = S_END;
                     res_next   = RES_WIN;
                  end else if (lose_q == WIN_TARGET) begin
                     state_next = S_END;
                     res_next   = RES_LOSE;
                  end else begin
                     state_next = S_READY;
                  end
               end else begin
                  cnt_next = frame_cnt + 16'd1;
               end
            end
         end

         S_END: begin
            // Counter parks at END_FRAMES; only then is a restart accepted.
            if (frame_cnt == END_SAT) begin
               if (start_pulse) begin
                  state_next = S_START;
                  res_next   = RES_NONE;
                  cnt_next   = 16'd0;
               end
            end else if (frame_tick) begin
               cnt_next = frame_cnt + 16'd1;
            end
         end

         default: begin
            state_next = S_START;
            res_next   = RES_NONE;
            cnt_next   = 16'd0;
         end
      endcase
   end

   assign state_bin  = state_q;
   assign resoult    = res_q;
   assign score_win  = win_q;
   assign score_lose = lose_q;

endmodule
